// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state, default frame width and idle fill for the SPI responder.
package spi_pkg;
  localparam int DEF_DATA_W = 8;
  localparam logic [7:0] IDLE_FILL = 8'h00;
  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_e;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer with one-cycle rise/fall pulses on the synced level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign q_o = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/spi_responder.sv
// spi_responder: mode-0 SPI target oversampled by Clk, with a one-byte transmit holding register.
module spi_responder
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              spi_SS_n,
  input  logic              spi_SCLK,
  input  logic              spi_MOSI,
  output logic              spi_MISO,
  output logic              spi_MISO_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              frame_active
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] FILL = DATA_W'(IDLE_FILL);
  state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0] shift_in_q, shift_out_q, hold_q, hold_d, rx_data_q;
  logic hold_full_q, hold_full_d, tx_ready_q, rx_valid_q, underrun_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic ss, ss_rise, ss_fall, sclk, sclk_rise, sclk_fall, mosi, wr, load;
  sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
    .clk(Clk), .rst_n(Reset_n), .d_i(spi_SS_n), .q_o(ss), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(Clk), .rst_n(Reset_n), .d_i(spi_SCLK), .q_o(sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  // MOSI takes the same number of stages as SCLK so it lines up with the detected rise.
  always_ff @(posedge Clk) begin
    if (!Reset_n) mosi_q <= '0;
    else mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_MOSI};
  end
  assign mosi = mosi_q[SYNC_STAGES-1];
  assign wr = tx_valid & tx_ready_q;
  assign load = (state_q == ARMED && ss_fall) ||
                (state_q == SHIFT && !ss_rise && sclk_fall && cnt_q == '0);
  always_comb begin
    hold_d = wr ? tx_data : hold_q;
    hold_full_d = wr ? 1'b1 : (load ? 1'b0 : hold_full_q);
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_in_q <= '0;
      shift_out_q <= '0;
      hold_q <= '0;
      hold_full_q <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      tx_ready_q <= ~hold_full_d;
      rx_valid_q <= 1'b0;
      underrun_q <= load & ~hold_full_q;
      if (load) shift_out_q <= hold_full_q ? hold_q : FILL;
      case (state_q)
        IDLE: if (ss) state_q <= ARMED;
        ARMED: if (ss_fall) begin
          state_q <= SHIFT;
          cnt_q <= '0;
        end
        SHIFT: if (ss_rise) state_q <= ARMED;
        else begin
          if (sclk_rise) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            shift_in_q <= {shift_in_q[DATA_W-2:0], mosi};
            if (cnt_q == LAST) begin
              rx_data_q <= {shift_in_q[DATA_W-2:0], mosi};
              rx_valid_q <= 1'b1;
            end
          end
          // A fall with the counter at zero ends a byte and takes the load above instead.
          if (sclk_fall && cnt_q != '0) shift_out_q <= {shift_out_q[DATA_W-2:0], 1'b0};
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign spi_MISO = (state_q == SHIFT) & shift_out_q[DATA_W-1];
  assign spi_MISO_oe = (state_q == SHIFT);
  assign frame_active = (state_q == SHIFT) & ~ss;
  assign tx_ready = tx_ready_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;
  logic unused_sclk;
  assign unused_sclk = sclk;
endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed mode-0 frames against spi_responder with hand-computed expectations.
module tb_spi_responder;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic spi_SS_n = 1'b1, spi_SCLK = 1'b0, spi_MOSI = 1'b0;
  logic spi_MISO, spi_MISO_oe, tx_ready, rx_valid, underrun, frame_active;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic [7:0] rx_data;
  int ncmp = 0, nerr = 0;
  int rxv_cnt = 0, und_cnt = 0, oe_cnt = 0;
  int s_rx, s_und, s_oe;
  logic [7:0] mi, mi2, mi3;
  logic rdy;

  spi_responder dut (
    .Clk(Clk), .Reset_n(Reset_n), .spi_SS_n(spi_SS_n), .spi_SCLK(spi_SCLK), .spi_MOSI(spi_MOSI),
    .spi_MISO(spi_MISO), .spi_MISO_oe(spi_MISO_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun),
    .frame_active(frame_active)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    if (underrun) und_cnt <= und_cnt + 1;
    if (spi_MISO_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic snap();
    s_rx = rxv_cnt;
    s_und = und_cnt;
    s_oe = oe_cnt;
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge Clk);
    for (int i = 0; i < 50 && !tx_ready; i++) @(negedge Clk);
    if (!tx_ready) begin
      ncmp++; nerr++;
      $display("FAIL write_tx timeout: tx_ready=%b required 1", tx_ready);
    end
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge Clk);
    tx_valid = 1'b0;
  endtask

  task automatic ss_low();
    @(negedge Clk);
    spi_SS_n = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  // Sends nbits MSB-first; with last set, SS_n rises after the final SCLK rise.
  task automatic send_bits(input logic [7:0] mo, input int nbits, input logic last,
                           input logic inj, input logic [7:0] inj_d,
                           output logic [7:0] mi_o, output logic rdy_o);
    mi_o = '0;
    rdy_o = 1'b1;
    for (int i = 7; i >= 8 - nbits; i--) begin
      @(negedge Clk);
      spi_MOSI = mo[i];
      repeat (4) @(negedge Clk);
      mi_o = {mi_o[6:0], spi_MISO};
      spi_SCLK = 1'b1;
      repeat (4) @(negedge Clk);
      if (last && i == 8 - nbits) begin
        spi_SS_n = 1'b1;
        repeat (4) @(negedge Clk);
      end
      spi_SCLK = 1'b0;
      if (inj && i == 0) begin
        @(posedge Clk);
        @(posedge Clk);
        #1 tx_data = inj_d;
        tx_valid = 1'b1;
        @(posedge Clk);
        #1 tx_valid = 1'b0;
        rdy_o = tx_ready;
      end
    end
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    ncmp += 7;
    if (tx_ready !== 1'b1) begin nerr++; $display("FAIL reset tx_ready: got %b want 1", tx_ready); end
    if (rx_valid !== 1'b0) begin nerr++; $display("FAIL reset rx_valid: got %b want 0", rx_valid); end
    if (rx_data !== 8'h00) begin nerr++; $display("FAIL reset rx_data: got %h want 00", rx_data); end
    if (underrun !== 1'b0) begin nerr++; $display("FAIL reset underrun: got %b want 0", underrun); end
    if (spi_MISO !== 1'b0) begin nerr++; $display("FAIL reset MISO: got %b want 0", spi_MISO); end
    if (spi_MISO_oe !== 1'b0) begin nerr++; $display("FAIL reset MISO_oe: got %b want 0", spi_MISO_oe); end
    if (frame_active !== 1'b0) begin nerr++; $display("FAIL reset frame_active: got %b want 0", frame_active); end
    Reset_n = 1'b1;
    repeat (6) @(negedge Clk);
  endtask

  task automatic test_basic();
    write_tx(8'hA5);
    snap();
    ss_low();
    ncmp += 2;
    if (frame_active !== 1'b1) begin nerr++; $display("FAIL basic frame_active: got %b want 1", frame_active); end
    if (spi_MISO_oe !== 1'b1) begin nerr++; $display("FAIL basic MISO_oe: got %b want 1", spi_MISO_oe); end
    send_bits(8'h3C, 8, 1'b1, 1'b0, 8'h00, mi, rdy);
    ncmp += 5;
    if (mi !== 8'hA5) begin nerr++; $display("FAIL basic MISO byte: got %h want a5", mi); end
    if (rx_data !== 8'h3C) begin nerr++; $display("FAIL basic rx_data: got %h want 3c", rx_data); end
    if (rxv_cnt - s_rx !== 1) begin nerr++; $display("FAIL basic rx_valid pulses: got %0d want 1", rxv_cnt - s_rx); end
    if (und_cnt - s_und !== 0) begin nerr++; $display("FAIL basic underrun pulses: got %0d want 0", und_cnt - s_und); end
    if (spi_MISO_oe !== 1'b0) begin nerr++; $display("FAIL basic MISO_oe after frame: got %b want 0", spi_MISO_oe); end
  endtask

  task automatic test_two_byte();
    write_tx(8'h12);
    snap();
    ss_low();
    write_tx(8'h34);
    send_bits(8'hC1, 8, 1'b0, 1'b0, 8'h00, mi, rdy);
    send_bits(8'hD2, 8, 1'b1, 1'b0, 8'h00, mi2, rdy);
    ncmp += 5;
    if (mi !== 8'h12) begin nerr++; $display("FAIL two_byte MISO byte0: got %h want 12", mi); end
    if (mi2 !== 8'h34) begin nerr++; $display("FAIL two_byte MISO byte1: got %h want 34", mi2); end
    if (und_cnt - s_und !== 0) begin nerr++; $display("FAIL two_byte underrun pulses: got %0d want 0", und_cnt - s_und); end
    if (rxv_cnt - s_rx !== 2) begin nerr++; $display("FAIL two_byte rx_valid pulses: got %0d want 2", rxv_cnt - s_rx); end
    if (rx_data !== 8'hD2) begin nerr++; $display("FAIL two_byte rx_data: got %h want d2", rx_data); end
  endtask

  task automatic test_underrun();
    snap();
    ss_low();
    ncmp += 1;
    if (und_cnt - s_und !== 1) begin nerr++; $display("FAIL underrun at SS fall: got %0d want 1", und_cnt - s_und); end
    send_bits(8'h6E, 8, 1'b1, 1'b0, 8'h00, mi, rdy);
    ncmp += 3;
    if (mi !== 8'h00) begin nerr++; $display("FAIL underrun MISO byte: got %h want 00", mi); end
    if (und_cnt - s_und !== 1) begin nerr++; $display("FAIL underrun total pulses: got %0d want 1", und_cnt - s_und); end
    if (rx_data !== 8'h6E) begin nerr++; $display("FAIL underrun rx_data: got %h want 6e", rx_data); end
  endtask

  task automatic test_abort();
    write_tx(8'hE7);
    snap();
    ss_low();
    write_tx(8'h99);
    send_bits(8'hFF, 5, 1'b1, 1'b0, 8'h00, mi, rdy);
    ncmp += 2;
    if (rxv_cnt - s_rx !== 0) begin nerr++; $display("FAIL abort rx_valid pulses: got %0d want 0", rxv_cnt - s_rx); end
    if (rx_data !== 8'h6E) begin nerr++; $display("FAIL abort rx_data kept: got %h want 6e", rx_data); end
    ss_low();
    send_bits(8'h81, 8, 1'b1, 1'b0, 8'h00, mi, rdy);
    ncmp += 3;
    if (mi !== 8'h99) begin nerr++; $display("FAIL abort held byte: got %h want 99", mi); end
    if (rx_data !== 8'h81) begin nerr++; $display("FAIL abort next rx_data: got %h want 81", rx_data); end
    if (rxv_cnt - s_rx !== 1) begin nerr++; $display("FAIL abort next rx_valid: got %0d want 1", rxv_cnt - s_rx); end
  endtask

  task automatic test_back_to_back();
    write_tx(8'hC3);
    snap();
    ss_low();
    send_bits(8'h11, 8, 1'b0, 1'b1, 8'h77, mi, rdy);
    send_bits(8'h22, 8, 1'b0, 1'b0, 8'h00, mi2, rdy);
    send_bits(8'h33, 8, 1'b1, 1'b0, 8'h00, mi3, rdy);
    ncmp += 6;
    if (mi !== 8'hC3) begin nerr++; $display("FAIL b2b MISO byte0: got %h want c3", mi); end
    if (mi2 !== 8'h00) begin nerr++; $display("FAIL b2b MISO byte1 old: got %h want 00", mi2); end
    if (mi3 !== 8'h77) begin nerr++; $display("FAIL b2b MISO byte2: got %h want 77", mi3); end
    if (und_cnt - s_und !== 1) begin nerr++; $display("FAIL b2b underrun pulses: got %0d want 1", und_cnt - s_und); end
    if (rxv_cnt - s_rx !== 3) begin nerr++; $display("FAIL b2b rx_valid pulses: got %0d want 3", rxv_cnt - s_rx); end
    if (rx_data !== 8'h33) begin nerr++; $display("FAIL b2b rx_data: got %h want 33", rx_data); end
  endtask

  task automatic test_b2b_ready();
    write_tx(8'h4B);
    ss_low();
    send_bits(8'h00, 8, 1'b0, 1'b1, 8'h5D, mi, rdy);
    ncmp += 1;
    if (rdy !== 1'b0) begin nerr++; $display("FAIL b2b tx_ready after load+write: got %b want 0", rdy); end
    send_bits(8'h00, 8, 1'b0, 1'b0, 8'h00, mi2, rdy);
    send_bits(8'h00, 8, 1'b1, 1'b0, 8'h00, mi3, rdy);
    ncmp += 2;
    if (mi !== 8'h4B) begin nerr++; $display("FAIL b2b2 MISO byte0: got %h want 4b", mi); end
    if (mi3 !== 8'h5D) begin nerr++; $display("FAIL b2b2 MISO byte2: got %h want 5d", mi3); end
  endtask

  task automatic test_reset_mid();
    ss_low();
    send_bits(8'hFF, 3, 1'b0, 1'b0, 8'h00, mi, rdy);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    snap();
    ncmp += 2;
    if (spi_MISO_oe !== 1'b0) begin nerr++; $display("FAIL reset_mid MISO_oe: got %b want 0", spi_MISO_oe); end
    if (frame_active !== 1'b0) begin nerr++; $display("FAIL reset_mid frame_active: got %b want 0", frame_active); end
    send_bits(8'hFF, 8, 1'b1, 1'b0, 8'h00, mi, rdy);
    ncmp += 2;
    if (rxv_cnt - s_rx !== 0) begin nerr++; $display("FAIL reset_mid rx_valid pulses: got %0d want 0", rxv_cnt - s_rx); end
    if (oe_cnt - s_oe !== 0) begin nerr++; $display("FAIL reset_mid MISO_oe cycles: got %0d want 0", oe_cnt - s_oe); end
    write_tx(8'h3C);
    snap();
    ss_low();
    send_bits(8'h5A, 8, 1'b1, 1'b0, 8'h00, mi, rdy);
    ncmp += 3;
    if (mi !== 8'h3C) begin nerr++; $display("FAIL reset_mid next MISO: got %h want 3c", mi); end
    if (rx_data !== 8'h5A) begin nerr++; $display("FAIL reset_mid next rx_data: got %h want 5a", rx_data); end
    if (rxv_cnt - s_rx !== 1) begin nerr++; $display("FAIL reset_mid next rx_valid: got %0d want 1", rxv_cnt - s_rx); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_byte();
    test_underrun();
    test_abort();
    test_back_to_back();
    test_b2b_ready();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
